// File: rtl/bnn_pkg.sv
// bnn_pkg: shared definitions for the binary-weight convolution engine.
//   state_t     - control FSM states
//   lat(k)      - input-to-output latency in cycles for a k x k kernel
//   acc_w(dw,k) - accumulator width that cannot overflow for k*k products
package bnn_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD_W = 2'd1,
      S_RUN    = 2'd2,
      S_DRAIN  = 2'd3
   } state_t;

   // product register + adder-tree levels + bias register
   function automatic int lat(input int k);
      return $clog2(k * k) + 2;
   endfunction

   function automatic int acc_w(input int dw, input int k);
      return dw + $clog2(k * k) + 1;
   endfunction

endpackage

// File: rtl/bnn_adder_tree.sv
// bnn_adder_tree: fully registered binary adder tree.
//   N inputs of W bits are zero-padded to the next power of two and reduced
//   one pairwise level per cycle, giving $clog2(N) cycles of latency.
// Ports:
//   clk, rstn - clock, asynchronous active-low reset
//   i_valid   - qualifier travelling alongside i_data
//   i_data    - N packed operands, operand 0 in the LSBs
//   o_valid   - i_valid delayed by the tree depth
//   o_sum     - two's-complement sum of the operands (modulo 2^W)
module bnn_adder_tree #(
   parameter int N = 25,
   parameter int W = 14
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           i_valid,
   input  logic [N*W-1:0] i_data,
   output logic           o_valid,
   output logic [W-1:0]   o_sum
);

   localparam int L = $clog2(N);
   localparam int P = 1 << L;

   logic [W-1:0] w_pad [P];
   logic [W-1:0] r_lvl [L][P];   // r_lvl[l] holds P>>(l+1) live partial sums
   logic [L-1:0] r_vld;

   for (genvar g = 0; g < P; g++) begin : g_pad
      if (g < N) begin : g_real
         assign w_pad[g] = i_data[g*W +: W];
      end else begin : g_zero
         assign w_pad[g] = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_vld <= '0;
         for (int l = 0; l < L; l++)
            for (int i = 0; i < P; i++)
               r_lvl[l][i] <= '0;
      end else begin
         r_vld <= {r_vld[L-2:0], i_valid};
         for (int i = 0; i < P / 2; i++)
            r_lvl[0][i] <= w_pad[2*i] + w_pad[2*i+1];
         for (int l = 1; l < L; l++)
            for (int i = 0; i < (P >> (l + 1)); i++)
               r_lvl[l][i] <= r_lvl[l-1][2*i] + r_lvl[l-1][2*i+1];
      end
   end

   assign o_valid = r_vld[L-1];
   assign o_sum   = r_lvl[L-1][0];

endmodule

// File: rtl/bnn_conv_engine.sv
// bnn_conv_engine: streaming K x K convolution with binary (+1/-1) weights.
//   A frame is: start -> K*K weight bits -> column vectors for every row strip
//   -> drain of the pipeline. Each accepted column shifts into a K-column
//   window; once a row strip has K columns, every accept yields one output.
// Handshake: the inputs have no back-pressure. A weight bit is taken on any
//   cycle with weight_valid high in LOAD_W; a column is taken on any cycle
//   with taps_valid high in RUN. ovalid marks dout/dout_bin for one cycle and
//   nothing downstream can stall it.
// Ports:
//   clk, rstn            - clock, asynchronous active-low reset
//   start                - begins a frame (IDLE only); latches cfg_ni, cfg_bias
//   cfg_ni, cfg_bias     - image width and output bias
//   weight_valid/_bit    - serial weight stream, row-major, 1 = +1, 0 = -1
//   taps_valid, taps     - column vector, row 0 in the MSBs
//   dout, dout_bin       - sum + bias and its sign activation (1 when >= 0)
//   ovalid, done         - output strobe, last-output-of-frame strobe
//   busy                 - high whenever not IDLE
//   o_dbg_state          - current FSM state for observation
module bnn_conv_engine
   import bnn_pkg::*;
#(
   parameter int K      = 5,
   parameter int DW     = 8,
   parameter int NI_MAX = 28,
   parameter int ACC_W  = acc_w(DW, K)
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        start,
   input  logic [$clog2(NI_MAX+1)-1:0] cfg_ni,
   input  logic signed [ACC_W-1:0]     cfg_bias,
   input  logic                        weight_valid,
   input  logic                        weight_bit,
   input  logic                        taps_valid,
   input  logic [K*DW-1:0]             taps,
   output logic signed [ACC_W-1:0]     dout,
   output logic                        dout_bin,
   output logic                        ovalid,
   output logic                        busy,
   output logic                        done,
   output logic [1:0]                  o_dbg_state
);

   localparam int NW  = K * K;
   localparam int LAT = lat(K);
   localparam int CW  = $clog2(NI_MAX + 1);
   localparam int WCW = $clog2(NW);

   state_t              r_state;
   logic                r_busy;
   logic [CW-1:0]       r_ni, r_col, r_row;
   logic [ACC_W-1:0]    r_bias;
   logic [NW-1:0]       r_w;          // bit r*K+c is kernel tap [r][c]
   logic [WCW-1:0]      r_wcnt;
   logic [DW-1:0]       r_win [K][K]; // [column slot][row], slot K-1 newest
   logic [DW-1:0]       w_nwin [K][K];
   logic [NW*ACC_W-1:0] w_prod, r_prod;
   logic                r_pvld;
   logic [LAT-1:0]      r_lastp;
   logic [ACC_W-1:0]    r_dout;
   logic                r_dout_bin, r_ovalid;
   logic                w_acc, w_qual, w_last, w_col_end, w_row_end, w_done;
   logic                w_tvld;
   logic [ACC_W-1:0]    w_tsum, w_biased;

   // +x for weight 1, -x for weight 0; sign-extended first so -(-2^(DW-1)) fits
   function automatic logic [ACC_W-1:0] signed_term(input logic [DW-1:0] x,
                                                    input logic w);
      logic [ACC_W-1:0] ext;
      ext = {{(ACC_W-DW){x[DW-1]}}, x};
      return w ? ext : (~ext + 1'b1);
   endfunction

   assign w_acc     = (r_state == S_RUN) && taps_valid;
   assign w_col_end = (r_col == r_ni - 1'b1);
   assign w_row_end = (r_row == r_ni - CW'(K));
   // columns left over from the previous row strip are never used because
   // no output is produced until K new columns have arrived in this strip
   assign w_qual    = w_acc && (r_col >= CW'(K - 1));
   assign w_last    = w_acc && w_col_end && w_row_end;
   assign w_done    = r_lastp[LAT-1];

   // window as it will look after this cycle's accept; products use it so
   // the accepted column contributes without an extra cycle
   always_comb begin
      for (int c = 0; c < K - 1; c++)
         for (int r = 0; r < K; r++)
            w_nwin[c][r] = r_win[c+1][r];
      for (int r = 0; r < K; r++)
         w_nwin[K-1][r] = taps[(K-1-r)*DW +: DW];
   end

   always_comb begin
      w_prod = '0;
      for (int i = 0; i < NW; i++)
         w_prod[i*ACC_W +: ACC_W] = signed_term(w_nwin[i % K][i / K], r_w[i]);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_ni    <= '0;
         r_bias  <= '0;
         r_w     <= '0;
         r_wcnt  <= '0;
         r_col   <= '0;
         r_row   <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_state <= S_LOAD_W;
               r_busy  <= 1'b1;
               r_ni    <= cfg_ni;
               r_bias  <= cfg_bias;
               r_wcnt  <= '0;
               r_col   <= '0;
               r_row   <= '0;
            end
            S_LOAD_W: if (weight_valid) begin
               r_w[r_wcnt] <= weight_bit;
               r_wcnt      <= r_wcnt + 1'b1;
               if (r_wcnt == WCW'(NW - 1)) r_state <= S_RUN;
            end
            S_RUN: if (taps_valid) begin
               if (w_col_end) begin
                  r_col <= '0;
                  r_row <= r_row + 1'b1;
                  if (w_row_end) r_state <= S_DRAIN;
               end else begin
                  r_col <= r_col + 1'b1;
               end
            end
            S_DRAIN: if (w_done) begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   bnn_adder_tree #(.N(NW), .W(ACC_W)) u_tree (
      .clk     (clk),
      .rstn    (rstn),
      .i_valid (r_pvld),
      .i_data  (r_prod),
      .o_valid (w_tvld),
      .o_sum   (w_tsum)
   );

   assign w_biased = w_tsum + r_bias;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int c = 0; c < K; c++)
            for (int r = 0; r < K; r++)
               r_win[c][r] <= '0;
         r_prod     <= '0;
         r_pvld     <= 1'b0;
         r_lastp    <= '0;
         r_dout     <= '0;
         r_dout_bin <= 1'b0;
         r_ovalid   <= 1'b0;
      end else begin
         if (w_acc)
            for (int c = 0; c < K; c++)
               for (int r = 0; r < K; r++)
                  r_win[c][r] <= w_nwin[c][r];
         r_prod   <= w_prod;
         r_pvld   <= w_qual;
         r_lastp  <= {r_lastp[LAT-2:0], w_last};
         r_ovalid <= w_tvld;
         if (w_tvld) begin
            r_dout     <= w_biased;
            r_dout_bin <= ~w_biased[ACC_W-1];
         end
      end
   end

   assign dout        = r_dout;
   assign dout_bin    = r_dout_bin;
   assign ovalid      = r_ovalid;
   assign busy        = r_busy;
   assign done        = w_done;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bnn_conv_engine.sv
module tb_bnn_conv_engine;
  localparam int K      = 5;
  localparam int DW     = 8;
  localparam int NI_MAX = 28;
  localparam int ACC_W  = DW + $clog2(K*K) + 1;
  localparam int LAT    = $clog2(K*K) + 2;
  localparam int CW     = $clog2(NI_MAX+1);

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rstn;
  logic              start, weight_valid, weight_bit, taps_valid;
  logic [CW-1:0]     cfg_ni;
  logic [ACC_W-1:0]  cfg_bias;
  logic [K*DW-1:0]   taps;
  logic [ACC_W-1:0]  dout;
  logic              dout_bin, ovalid, busy, done;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  bnn_conv_engine #(.K(K), .DW(DW), .NI_MAX(NI_MAX), .ACC_W(ACC_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_ni(cfg_ni), .cfg_bias(cfg_bias),
    .weight_valid(weight_valid), .weight_bit(weight_bit), .taps_valid(taps_valid),
    .taps(taps), .dout(dout), .dout_bin(dout_bin), .ovalid(ovalid), .busy(busy),
    .done(done), .o_dbg_state(dbg_state)
  );

  // ---------------- reference data ----------------
  int  img [NI_MAX][NI_MAX];
  bit  wt  [K*K];

  function automatic int model(int orow, int ocol);
    int s = 0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        s += wt[r*K+c] ? img[orow+r][ocol+c] : -img[orow+r][ocol+c];
    return s;
  endfunction

  function automatic logic [K*DW-1:0] col_taps(int row, int col);
    logic [K*DW-1:0] t;
    t = '0;
    for (int r = 0; r < K; r++) t[(K-1-r)*DW +: DW] = DW'(img[row+r][col]);
    return t;
  endfunction

  function automatic logic [K*DW-1:0] rnd_taps();
    return (K*DW)'({$urandom(), $urandom()});
  endfunction

  // ---------------- scoreboard ----------------
  logic [ACC_W-1:0] exp_q[$];
  bit               bin_q[$];
  int               cyc_q[$];
  bit               last_q[$];
  logic [ACC_W-1:0] hold;
  int total = 0, bad = 0, n_obs = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ovalid === 1'b1) begin
        n_obs++;
        if (exp_q.size() == 0) begin
          chk("spurious_ovalid", 32'(ovalid), 32'(0));
        end else begin
          logic [ACC_W-1:0] ev;
          bit eb, el;
          int ec;
          ev = exp_q.pop_front(); eb = bin_q.pop_front();
          ec = cyc_q.pop_front(); el = last_q.pop_front();
          chk("dout", 32'(dout), 32'(ev));
          chk("dout_bin", 32'(dout_bin), 32'(eb));
          chk("latency", 32'(cyc), 32'(ec));
          chk("done_with_ovalid", 32'(done), 32'(el));
          hold = ev;
        end
      end else begin
        chk("done_without_ovalid", 32'(done), 32'(0));
        chk("dout_hold", 32'(dout), 32'(hold));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic abort_frame();
    taps_valid = 1'b0; weight_valid = 1'b0;
    #2 rstn = 1'b0;
    exp_q.delete(); bin_q.delete(); cyc_q.delete(); last_q.delete();
    hold = '0;
    #1;
    chk("abort_dout", 32'(dout), 32'(0));
    chk("abort_dout_bin", 32'(dout_bin), 32'(0));
    chk("abort_ovalid", 32'(ovalid), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic run_frame(input int ni, input int bias, input int bub, input int gap,
                           input bit mid_start, input int abort_row);
    int s;
    n_obs = 0;
    @(negedge clk);
    start = 1'b1; cfg_ni = CW'(ni); cfg_bias = ACC_W'(bias);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(1));
    // config changes while busy must not matter
    cfg_ni = CW'($urandom_range(K, NI_MAX)); cfg_bias = ACC_W'($urandom());
    for (int i = 0; i < K*K; i++) begin
      while ($urandom_range(0, 99) < gap) begin
        weight_valid = 1'b0; weight_bit = 1'($urandom());
        taps_valid = 1'($urandom()); taps = rnd_taps();
        @(negedge clk);
      end
      weight_valid = 1'b1; weight_bit = wt[i];
      taps_valid = 1'($urandom()); taps = rnd_taps();
      @(negedge clk);
    end
    for (int row = 0; row <= ni - K; row++) begin
      for (int col = 0; col < ni; col++) begin
        if (row == abort_row && col == 0) begin
          abort_frame();
          return;
        end
        while ($urandom_range(0, 99) < bub) begin
          taps_valid = 1'b0; taps = rnd_taps();
          weight_valid = 1'($urandom()); weight_bit = 1'($urandom());
          @(negedge clk);
        end
        taps_valid = 1'b1; taps = col_taps(row, col);
        weight_valid = 1'($urandom()); weight_bit = 1'($urandom());
        if (mid_start && row == 1 && col == 2) start = 1'b1;
        if (col >= K - 1) begin
          s = model(row, col - K + 1) + bias;
          exp_q.push_back(ACC_W'(s));
          bin_q.push_back(s >= 0);
          cyc_q.push_back(cyc + LAT);
          last_q.push_back(row == ni - K && col == ni - 1);
        end
        @(negedge clk);
        start = 1'b0;
      end
    end
    weight_valid = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      taps_valid = 1'($urandom()); taps = rnd_taps();
      @(negedge clk); #1;
    end
    taps_valid = 1'b0;
    chk("drain_empty", 32'(exp_q.size()), 32'(0));
    chk("out_count", 32'(n_obs), 32'((ni-K+1)*(ni-K+1)));
    @(negedge clk);
    chk("busy_after_frame", 32'(busy), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0; start = 1'b0; weight_valid = 1'b0; weight_bit = 1'b0;
    taps_valid = 1'b0; taps = '0; cfg_ni = '0; cfg_bias = '0; hold = '0;
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'(0));
    chk("rst_dout_bin", 32'(dout_bin), 32'(0));
    chk("rst_ovalid", 32'(ovalid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    rstn = 1'b1; mon_en = 1'b1;
    @(negedge clk);

    // all +1 weights, unit pixels: every output is 25
    for (int i = 0; i < K*K; i++) wt[i] = 1'b1;
    for (int y = 0; y < NI_MAX; y++) for (int x = 0; x < NI_MAX; x++) img[y][x] = 1;
    run_frame(12, 0, 0, 0, 1'b0, -1);

    // all -1 weights, most negative pixels: +3200 without overflow
    for (int i = 0; i < K*K; i++) wt[i] = 1'b0;
    for (int y = 0; y < NI_MAX; y++) for (int x = 0; x < NI_MAX; x++) img[y][x] = -128;
    run_frame(8, 0, 0, 0, 1'b0, -1);

    // alternating weights, pixels 3, bias -4: -1 and dout_bin 0
    for (int i = 0; i < K*K; i++) wt[i] = (i % 2 == 0);
    for (int y = 0; y < NI_MAX; y++) for (int x = 0; x < NI_MAX; x++) img[y][x] = 3;
    run_frame(7, -4, 0, 0, 1'b0, -1);

    // full-size random frame with bubbles, weight gaps and a start mid-RUN
    for (int i = 0; i < K*K; i++) wt[i] = 1'($urandom());
    for (int y = 0; y < NI_MAX; y++) for (int x = 0; x < NI_MAX; x++)
      img[y][x] = $urandom_range(0, 255) - 128;
    run_frame(28, $urandom_range(0, 400) - 200, 30, 30, 1'b1, -1);

    // smallest image: exactly one output
    for (int i = 0; i < K*K; i++) wt[i] = 1'($urandom());
    run_frame(K, $urandom_range(0, 400) - 200, 20, 20, 1'b0, -1);

    // reset at row 3, then a clean frame
    run_frame(10, 5, 10, 0, 1'b0, 3);
    for (int i = 0; i < K*K; i++) wt[i] = 1'($urandom());
    for (int y = 0; y < NI_MAX; y++) for (int x = 0; x < NI_MAX; x++)
      img[y][x] = $urandom_range(0, 255) - 128;
    run_frame(9, $urandom_range(0, 400) - 200, 20, 10, 1'b0, -1);

    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
